cpu_sequencer: RTL and testbench

//  Multi-cycle controller for the X/Y/Z/ULA datapath. Drives the 4-bit program counter into program memory and latches {val, func}.

---
 rtl/cpu_sequencer_if.sv | 27 ++
 rtl/cpu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bus between the X/Y/Z/ULA sequencer and its environment: program memory
// port, start handshake, datapath control buses and status flags.
interface cpu_sequencer_if #(
    parameter int PC_W = 4
);
    logic            start;
    logic [3:0]      instr_val;
    logic [3:0]      instr_func;
    logic [PC_W-1:0] pc;
    logic [1:0]      ctl_x;
    logic [2:0]      ctl_y;
    logic [1:0]      ctl_z;
    logic            ctl_ula;
    logic            busy;
    logic            done;
    logic            illegal;

    modport master (
        input  start, instr_val, instr_func,
        output pc, ctl_x, ctl_y, ctl_z, ctl_ula, busy, done, illegal
    );

    modport slave (
        output start, instr_val, instr_func,
        input  pc, ctl_x, ctl_y, ctl_z, ctl_ula, busy, done, illegal
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the X/Y/Z/ULA datapath.
// All outputs are registered; control buses are non-hold only in EXEC.
module cpu_sequencer #(
    parameter int PC_W         = 4,
    parameter int PROG_LEN     = 16,
    parameter int STOP_ON_WRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDX  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOVZ = 4'h4;
    localparam logic [3:0] OP_CLR  = 4'h5;
    localparam logic [3:0] OP_SHRY = 4'h6;
    localparam logic [3:0] OP_SHLY = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [PC_W-1:0] PC_ZERO    = {PC_W{1'b0}};
    localparam logic [PC_W-1:0] PC_ONE     = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] LAST_PC    = PC_W'(PROG_LEN - 1);
    localparam logic [31:0]     PROG_LEN_W = 32'(PROG_LEN);

    // Packed control word: {ctl_x[1:0], ctl_y[2:0], ctl_z[1:0], ctl_ula}
    function automatic logic [7:0] decode_ctl(input logic [3:0] func);
        logic [7:0] c;
        c = 8'h00;
        case (func)
            OP_LDX:  c = 8'b01_000_00_0;
            OP_ADD:  c = 8'b00_001_00_0;
            OP_SUB:  c = 8'b00_001_00_1;
            OP_MOVZ: c = 8'b00_000_01_0;
            OP_CLR:  c = 8'b10_010_10_0;
            OP_SHRY: c = 8'b00_011_00_0;
            OP_SHLY: c = 8'b00_100_00_0;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic is_undefined(input logic [3:0] func);
        return (func > OP_JMP) && (func != OP_HALT);
    endfunction

    state_t          state_r, state_nxt_s;
    logic [PC_W-1:0] pc_r, pc_nxt_s;
    logic [3:0]      op_val_r, op_val_nxt_s;
    logic [3:0]      op_func_r, op_func_nxt_s;
    logic [7:0]      ctl_r, ctl_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            illegal_r, illegal_nxt_s;
    logic            jmp_ok_s;

    // A jump target outside the program image cannot be fetched.
    assign jmp_ok_s = ({28'd0, op_val_r} < PROG_LEN_W);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, pc, operand latch and registered-output next values
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        op_val_nxt_s  = op_val_r;
        op_func_nxt_s = op_func_r;
        ctl_nxt_s     = 8'h00;
        illegal_nxt_s = illegal_r;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (bus.start) begin
                    state_nxt_s   = ST_FETCH;
                    pc_nxt_s      = PC_ZERO;
                    illegal_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            ST_FETCH: begin
                op_val_nxt_s  = bus.instr_val;
                op_func_nxt_s = bus.instr_func;
                state_nxt_s   = ST_DECODE;
            end
            ST_DECODE: begin
                // Registered here so the control word is live exactly during EXEC.
                ctl_nxt_s   = decode_ctl(op_func_r);
                state_nxt_s = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt_s = ST_FETCH;
                if (op_func_r == OP_HALT) begin
                    state_nxt_s = ST_HALT;
                end else if (op_func_r == OP_JMP) begin
                    if (jmp_ok_s) begin
                        pc_nxt_s = PC_W'(op_val_r);
                    end else begin
                        illegal_nxt_s = 1'b1;
                        state_nxt_s   = ST_HALT;
                    end
                end else begin
                    if (is_undefined(op_func_r)) begin
                        illegal_nxt_s = 1'b1;
                    end else begin
                        illegal_nxt_s = illegal_r;
                    end
                    if (pc_r == LAST_PC) begin
                        pc_nxt_s = PC_ZERO;
                        if (STOP_ON_WRAP != 0) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_FETCH;
                        end
                    end else begin
                        pc_nxt_s = pc_r + PC_ONE;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = PC_ZERO;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_DECODE) ||
                     (state_nxt_s == ST_EXEC);
        done_nxt_s = (state_r == ST_EXEC) && (state_nxt_s == ST_HALT);
    end

    // Datapath registers: pc, latched instruction and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= PC_ZERO;
            op_val_r  <= 4'h0;
            op_func_r <= 4'h0;
            ctl_r     <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            pc_r      <= pc_nxt_s;
            op_val_r  <= op_val_nxt_s;
            op_func_r <= op_func_nxt_s;
            ctl_r     <= ctl_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign bus.pc      = pc_r;
    assign bus.ctl_x   = ctl_r[7:6];
    assign bus.ctl_y   = ctl_r[5:3];
    assign bus.ctl_z   = ctl_r[2:1];
    assign bus.ctl_ula = ctl_r[0];
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.illegal = illegal_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: opcode vector table plus multi-cycle
// program runs against a small X/Y/Z datapath model and program memories.
module tb_cpu_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.PC_W(4)) bus0 ();
    cpu_sequencer_if #(.PC_W(4)) bus1 ();

    cpu_sequencer #(.PC_W(4), .PROG_LEN(16), .STOP_ON_WRAP(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    cpu_sequencer #(.PC_W(4), .PROG_LEN(12), .STOP_ON_WRAP(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    logic [3:0] m0_val [16];
    logic [3:0] m0_func[16];
    logic [3:0] m1_val [16];
    logic [3:0] m1_func[16];

    assign bus0.instr_val  = m0_val[bus0.pc];
    assign bus0.instr_func = m0_func[bus0.pc];
    assign bus1.instr_val  = m1_val[bus1.pc];
    assign bus1.instr_func = m1_func[bus1.pc];

    logic [7:0] ctl0;
    assign ctl0 = {bus0.ctl_x, bus0.ctl_y, bus0.ctl_z, bus0.ctl_ula};

    // X/Y/Z/ULA datapath driven by dut0's control buses
    logic [3:0] dx, dy, dz, ula;
    assign ula = bus0.ctl_ula ? (dx - dy) : (dx + dy);
    always @(posedge clk) begin
        if (rst) begin
            dx <= 4'h0; dy <= 4'h0; dz <= 4'h0;
        end else begin
            case (bus0.ctl_x)
                2'b01:   dx <= m0_val[bus0.pc];
                2'b10:   dx <= 4'h0;
                2'b11:   dx <= dx >> 1;
                default: dx <= dx;
            endcase
            case (bus0.ctl_y)
                3'b001:  dy <= ula;
                3'b010:  dy <= 4'h0;
                3'b011:  dy <= dy >> 1;
                3'b100:  dy <= dy << 1;
                default: dy <= dy;
            endcase
            case (bus0.ctl_z)
                2'b01:   dz <= dy;
                2'b10:   dz <= 4'h0;
                2'b11:   dz <= dz >> 1;
                default: dz <= dz;
            endcase
        end
    end

    typedef struct {
        logic [3:0] func;
        logic [3:0] val;
        logic [7:0] ctl;
        logic [3:0] pc;
        logic       ill;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_mem0();
        for (int i = 0; i < 16; i++) begin
            m0_val[i]  = 4'h0;
            m0_func[i] = 4'h0;
        end
    endtask

    task automatic start0_pulse();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    int n, cnt_y, cnt_ula, cnt_sub, bad_pc, bad_busy, saw_done;

    initial begin
        vecs[0]  = '{4'h0, 4'h7, 8'h00, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'h1, 4'h3, 8'h40, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'h2, 4'h0, 8'h08, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'h3, 4'h0, 8'h09, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'h4, 4'h0, 8'h02, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{4'h5, 4'h0, 8'h94, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{4'h6, 4'h0, 8'h18, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'h7, 4'h0, 8'h20, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'h8, 4'h9, 8'h00, 4'd9, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'h9, 4'h0, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'hA, 4'h0, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{4'hC, 4'h0, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{4'hE, 4'h0, 8'h00, 4'd1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{4'hF, 4'h0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            m1_val[i] = 4'h0; m1_func[i] = 4'h0;
        end
        clear_mem0();

        // Reset state
        do_reset();
        check("rst_pc", bus0.pc, 4'd0);
        check("rst_ctl", ctl0, 8'h00);
        check("rst_busy", bus0.busy, 1'b0);
        check("rst_done", bus0.done, 1'b0);
        check("rst_illegal", bus0.illegal, 1'b0);
        tick();
        check("idle_no_start_busy", bus0.busy, 1'b0);

        // Single-instruction decode table
        for (int v = 0; v < 14; v++) begin
            do_reset();
            clear_mem0();
            m0_func[0] = vecs[v].func;
            m0_val[0]  = vecs[v].val;
            start0_pulse();
            check($sformatf("v%0d_fetch_busy", v), bus0.busy, 1'b1);
            tick();
            check($sformatf("v%0d_decode_ctl", v), ctl0, 8'h00);
            tick();
            check($sformatf("v%0d_exec_ctl", v), ctl0, vecs[v].ctl);
            tick();
            check($sformatf("v%0d_post_ctl", v), ctl0, 8'h00);
            check($sformatf("v%0d_pc", v), bus0.pc, vecs[v].pc);
            check($sformatf("v%0d_illegal", v), bus0.illegal, vecs[v].ill);
            check($sformatf("v%0d_busy", v), bus0.busy, vecs[v].busy);
            check($sformatf("v%0d_done", v), bus0.done, vecs[v].done);
        end

        // LDX 3, ADD, ADD, MOVZ, HALT
        do_reset();
        clear_mem0();
        m0_func[0] = 4'h1; m0_val[0] = 4'h3;
        m0_func[1] = 4'h2; m0_func[2] = 4'h2;
        m0_func[3] = 4'h4; m0_func[4] = 4'hF;
        start0_pulse();
        n = 0; cnt_y = 0;
        while (bus0.done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (bus0.ctl_y == 3'b001) cnt_y++;
        end
        check("prog_cycles", n, 15);
        check("prog_ctl_y_loads", cnt_y, 2);
        check("prog_x", dx, 4'd3);
        check("prog_y", dy, 4'd6);
        check("prog_z", dz, 4'd6);
        check("prog_halt_pc", bus0.pc, 4'd4);
        check("prog_halt_busy", bus0.busy, 1'b0);
        tick();
        check("done_one_cycle", bus0.done, 1'b0);

        // CLR, LDX 5, ADD, LDX 2, SUB, HALT -> Y = 2 - 5 = 0xD
        do_reset();
        clear_mem0();
        m0_func[0] = 4'h5;
        m0_func[1] = 4'h1; m0_val[1] = 4'h5;
        m0_func[2] = 4'h2;
        m0_func[3] = 4'h1; m0_val[3] = 4'h2;
        m0_func[4] = 4'h3;
        m0_func[5] = 4'hF;
        start0_pulse();
        n = 0; cnt_ula = 0; cnt_sub = 0;
        while (bus0.done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (bus0.ctl_ula) cnt_ula++;
            if (bus0.ctl_ula && bus0.ctl_y == 3'b001) cnt_sub++;
        end
        check("sub_cycles", n, 18);
        check("sub_ula_cycles", cnt_ula, 1);
        check("sub_ula_with_load", cnt_sub, 1);
        check("sub_y", dy, 4'hD);

        // NOP, NOP, JMP 0 with start held high: never halts, start ignored
        do_reset();
        clear_mem0();
        m0_func[2] = 4'h8; m0_val[2] = 4'h0;
        bus0.start = 1'b1;
        tick();
        bad_pc = 0; bad_busy = 0; saw_done = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus0.pc !== 4'((k / 3) % 3)) bad_pc++;
            if (bus0.busy !== 1'b1) bad_busy++;
            if (bus0.done !== 1'b0) saw_done++;
            tick();
        end
        bus0.start = 1'b0;
        check("jmp_pc_seq_errors", bad_pc, 0);
        check("jmp_busy_errors", bad_busy, 0);
        check("jmp_done_pulses", saw_done, 0);

        // 16 NOPs with STOP_ON_WRAP=1: halt after pc=15
        do_reset();
        clear_mem0();
        start0_pulse();
        n = 0;
        while (bus0.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("wrap_halt_cycles", n, 48);
        check("wrap_halt_pc", bus0.pc, 4'd0);
        check("wrap_halt_busy", bus0.busy, 1'b0);

        // rst during EXEC of ADD at pc=1
        do_reset();
        clear_mem0();
        m0_func[1] = 4'h2;
        start0_pulse();
        for (int k = 0; k < 5; k++) tick();
        check("rstexec_ctl_y_before", bus0.ctl_y, 3'b001);
        check("rstexec_pc_before", bus0.pc, 4'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstexec_pc", bus0.pc, 4'd0);
        check("rstexec_ctl_y", bus0.ctl_y, 3'b000);
        check("rstexec_busy", bus0.busy, 1'b0);
        check("rstexec_done", bus0.done, 1'b0);
        tick();
        check("rstexec_stays_idle", bus0.busy, 1'b0);

        // dut1 (PROG_LEN=12, no stop on wrap): out-of-range JMP, restart, wrap
        do_reset();
        m1_func[0] = 4'h8; m1_val[0] = 4'd12;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        tick();
        tick();
        check("badjmp_illegal", bus1.illegal, 1'b1);
        check("badjmp_done", bus1.done, 1'b1);
        check("badjmp_busy", bus1.busy, 1'b0);
        check("badjmp_pc", bus1.pc, 4'd0);
        m1_func[0] = 4'h0; m1_val[0] = 4'h0;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        check("restart_clears_illegal", bus1.illegal, 1'b0);
        check("restart_busy", bus1.busy, 1'b1);
        bad_busy = 0; saw_done = 0;
        for (int k = 0; k < 35; k++) begin
            tick();
            if (bus1.busy !== 1'b1) bad_busy++;
            if (bus1.done !== 1'b0) saw_done++;
        end
        check("nowrap_last_pc", bus1.pc, 4'd11);
        tick();
        check("nowrap_pc_wrapped", bus1.pc, 4'd0);
        check("nowrap_busy_after_wrap", bus1.busy, 1'b1);
        check("nowrap_busy_errors", bad_busy, 0);
        check("nowrap_done_pulses", saw_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
